load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Byte-addressed data-access stage between the RISC-V execute stage and the word-organised data memory (32-bit words, byte address, combinational read, write on posedge clk).
- Decodes funct3 for LB/LH/LW/LBU/LHU/SB/SH/SW. Checks alignment and range, and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data through a valid/ready request and single-pulse response handshake.

Parameters:
- ADDR_BITS, 10, width of the byte address driven to memory; valid byte addresses are 0 .. 2^ADDR_BITS-1.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the access.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  one-cycle pulse, access complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned, out-of-range or illegal funct3; qualified by resp_valid.
- mem_read_enable  output  1  to memory read_enable.
- mem_write_enable  output  1  to memory write_enable.
- mem_address  output  ADDR_BITS  word-aligned byte address; bits [1:0] are always 0.
- mem_input_data  output  32  to memory input_data.
- mem_output_data  input  32  from memory output_data (combinational).

Behaviour:
- Reset state:
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
  - mem_* enables=0, mem_address=0, mem_input_data=0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr and wdata.
  - Routing on accept:
    - Error → RESP.
    - SW → WRITE.
    - Any load, SB or SH → READ.
- Error conditions, any of which sends the request straight to RESP with no memory access:
  - Illegal funct3: loads accept 000/001/010/100/101 only; stores accept 000/001/010 only.
  - Misaligned halfword: addr[0]≠0 for LH/LHU/SH.
  - Misaligned word: addr[1:0]≠0 for LW/SW.
  - Out of range: addr[31:ADDR_BITS]≠0.
- READ:
  - mem_read_enable=1, mem_address={addr[ADDR_BITS-1:2],2'b00}.
  - mem_output_data is captured into word_q at the edge.
  - Next state: load → RESP; SB/SH → WRITE.
- WRITE:
  - mem_write_enable=1 and mem_input_data=merged word.
  - SW merged word: wdata.
  - SB merged word: word_q with byte lane addr[1:0] replaced by wdata[7:0].
  - SH merged word: word_q with halfword lane addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in every state except IDLE.
- Load extraction, little-endian:
  - LB/LH: selected lane sign-extended.
  - LBU/LHU: selected lane zero-extended.
  - LW: word_q unchanged.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
- Throughput: the earliest next accept is the cycle after RESP, so there is no back-to-back overlap.
- Memory enables and mem_address/mem_input_data are decoded from registered state, so there is no combinational path from req_* to mem_*.
- Reset mid-operation:
  - mem_write_enable is gated with !rst, so rst asserted during WRITE suppresses the memory write.
  - The FSM returns to IDLE and no resp_valid is produced for the aborted request.
- req_valid while not in IDLE is ignored; req_* fields are not sampled.

Test Plan:
- Memory word 0x10 preset to 0x8877_66F5. LB addr 0x11 → resp_rdata=0x0000_0066. LB addr 0x10 → 0xFFFF_FFF5. LBU addr 0x10 → 0x0000_00F5. Each with resp_valid exactly 2 cycles after accept.
- SB addr 0x22, wdata 0xAAAA_AA3C over word 0x1122_3344 → one READ then one WRITE of 0x113C_3344. resp_valid 3 cycles after accept. A following LW 0x20 → 0x113C_3344.
- SH addr 0x1E, wdata 0x0000_BEEF over word 0x0000_0000 at 0x1C → memory holds 0xBEEF_0000. LH 0x1E → 0xFFFF_BEEF. LHU 0x1E → 0x0000_BEEF.
- Errors, each giving resp_valid with resp_error=1 one cycle after accept, rdata=0, and no mem enable ever asserted:
  - LW addr 0x06.
  - SH addr 0x03.
  - Load funct3=011.
  - LW addr 0x0000_0400 with ADDR_BITS=10.
- rst asserted in the WRITE cycle of SW 0x40 ← 0xDEAD_BEEF → memory word unchanged, no resp_valid, req_ready=1 the next cycle.
- req_valid held high continuously with alternating requests → req_ready low in READ/WRITE/RESP. Each request is accepted only in IDLE, and every accepted request gets exactly one resp_valid pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Byte-addressed data-access stage between the execute stage and a
// word-organised data memory (32-bit words, combinational read, write on the
// rising clock edge).
//
// Supported accesses: LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores are done
// as a read-modify-write. Alignment, address range and funct3 are checked
// when the request is accepted. A failing request goes straight to the
// response and never touches memory.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_store            1 = store, 0 = load
//   req_funct3           RISC-V funct3 of the access
//   req_addr             byte address
//   req_wdata            store data (low byte/halfword for SB/SH)
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data, 0 for stores and errors
//   resp_error           misaligned / out of range / illegal funct3
//   mem_read_enable      memory read strobe (READ state)
//   mem_write_enable     memory write strobe (WRITE state, suppressed by rst)
//   mem_address          word-aligned byte address to memory
//   mem_input_data       merged write word to memory
//   mem_output_data      combinational read data from memory
module load_store_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_error,
  output logic                 mem_read_enable,
  output logic                 mem_write_enable,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [31:0]          mem_input_data,
  input  logic [31:0]          mem_output_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_store;
  logic [2:0]           r_funct3;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_word;
  logic                 r_error;
  logic                 w_req_error;
  logic                 w_mem_we;
  logic                 w_accept;

  // Any illegal funct3, misalignment or address beyond the memory flags an error.
  function automatic logic f_req_error(input logic i_store, input logic [2:0] i_f3,
                                       input logic [31:0] i_addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = |(i_addr >> ADDR_BITS);
    case (i_f3)
      3'b000: begin
        illegal    = 1'b0;
        misaligned = 1'b0;
      end
      3'b001: begin
        illegal    = 1'b0;
        misaligned = i_addr[0];
      end
      3'b010: begin
        illegal    = 1'b0;
        misaligned = |i_addr[1:0];
      end
      3'b100: begin
        illegal    = i_store;
        misaligned = 1'b0;
      end
      3'b101: begin
        illegal    = i_store;
        misaligned = i_addr[0];
      end
      default: begin
        illegal    = 1'b1;
        misaligned = 1'b0;
      end
    endcase
    return illegal | misaligned | out_of_range;
  endfunction

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [31:0] f_load(input logic [2:0] i_f3, input logic [1:0] i_lane,
                                         input logic [31:0] i_word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (i_lane)
      2'd0:    b = i_word[7:0];
      2'd1:    b = i_word[15:8];
      2'd2:    b = i_word[23:16];
      2'd3:    b = i_word[31:24];
      default: b = 8'd0;
    endcase
    h = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = i_word;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Build the word to write: SW replaces everything, SB/SH patch one lane of
  // the word fetched in READ.
  function automatic logic [31:0] f_merge(input logic [2:0] i_f3, input logic [1:0] i_lane,
                                          input logic [31:0] i_word, input logic [31:0] i_wdata);
    logic [31:0] res;
    res = i_word;
    case (i_f3)
      3'b000: begin
        case (i_lane)
          2'd0:    res[7:0]   = i_wdata[7:0];
          2'd1:    res[15:8]  = i_wdata[7:0];
          2'd2:    res[23:16] = i_wdata[7:0];
          2'd3:    res[31:24] = i_wdata[7:0];
          default: res        = i_word;
        endcase
      end
      3'b001: begin
        if (i_lane[1]) begin
          res[31:16] = i_wdata[15:0];
        end else begin
          res[15:0] = i_wdata[15:0];
        end
      end
      3'b010:  res = i_wdata;
      default: res = i_word;
    endcase
    return res;
  endfunction

  assign w_req_error = f_req_error(req_store, req_funct3, req_addr);
  assign w_accept    = (r_state == S_IDLE) && req_valid;

  // The reset term keeps an aborted store from reaching memory.
  assign mem_write_enable = w_mem_we & ~rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture on accept and read-word capture in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_word   <= 32'd0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_BITS-1:0];
        r_wdata  <= req_wdata;
        r_error  <= w_req_error;
      end
      if (r_state == S_READ) begin
        r_word <= mem_output_data;
      end
    end
  end

  // Next-state and output decode; all memory outputs come from registered state.
  always_comb begin
    w_next          = r_state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = 32'd0;
    resp_error      = 1'b0;
    mem_read_enable = 1'b0;
    w_mem_we        = 1'b0;
    mem_address     = '0;
    mem_input_data  = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (!req_valid) begin
          w_next = S_IDLE;
        end else if (w_req_error) begin
          w_next = S_RESP;
        end else if (req_store && (req_funct3 == 3'b010)) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        mem_read_enable = 1'b1;
        mem_address     = {r_addr[ADDR_BITS-1:2], 2'b00};
        w_next          = r_store ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        w_mem_we       = 1'b1;
        mem_address    = {r_addr[ADDR_BITS-1:2], 2'b00};
        mem_input_data = f_merge(r_funct3, r_addr[1:0], r_word, r_wdata);
        w_next         = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = r_error;
        resp_rdata = (r_error || r_store) ? 32'd0 : f_load(r_funct3, r_addr[1:0], r_word);
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [9:0]  mem_address;
  logic [31:0] mem_input_data;
  logic [31:0] mem_output_data;

  // Bench-side memory with a preload port that shares the write path.
  logic [31:0] env_mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  int          m_cnt = 0;
  logic        m_err;
  logic [31:0] m_rdata;
  logic        m_wr;
  logic [7:0]  m_widx;
  logic [31:0] m_wword;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_BITS(10)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .mem_output_data  (mem_output_data)
  );

  assign mem_output_data = env_mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (pl_en) env_mem[pl_idx] <= pl_data;
    else if (mem_write_enable) env_mem[mem_address[9:2]] <= mem_input_data;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Work out the full outcome of an accepted request from the access rules.
  task automatic model_accept(input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    logic        ok_f3;
    logic [31:0] w;
    logic [31:0] bytev;
    logic [31:0] halfv;
    logic [31:0] sh8;
    logic [31:0] sh16;
    logic [7:0]  idx;
    if (st) ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    m_err = !ok_f3
            || (((f3 == 3'd1) || (f3 == 3'd5)) && (a % 32'd2 != 32'd0))
            || ((f3 == 3'd2) && (a % 32'd4 != 32'd0))
            || (a >= 32'd1024);
    m_rdata = 32'd0;
    m_wr    = 1'b0;
    if (m_err) begin
      m_cnt = 1;
    end else begin
      idx   = 8'(a / 32'd4);
      w     = ref_mem[idx];
      sh8   = 32'd8 * (a % 32'd4);
      sh16  = 32'd16 * ((a / 32'd2) % 32'd2);
      bytev = (w >> sh8) & 32'hFF;
      halfv = (w >> sh16) & 32'hFFFF;
      if (!st) begin
        m_cnt = 2;
        case (f3)
          3'd0:    m_rdata = (bytev >= 32'd128) ? bytev - 32'd256 : bytev;
          3'd1:    m_rdata = (halfv >= 32'd32768) ? halfv - 32'd65536 : halfv;
          3'd2:    m_rdata = w;
          3'd4:    m_rdata = bytev;
          default: m_rdata = halfv;
        endcase
      end else begin
        m_wr   = 1'b1;
        m_widx = idx;
        m_cnt  = (f3 == 3'd2) ? 2 : 3;
        case (f3)
          3'd0:    m_wword = (w & ~(32'hFF << sh8)) | ((wd & 32'hFF) << sh8);
          3'd1:    m_wword = (w & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
          default: m_wword = wd;
        endcase
      end
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (pl_en) ref_mem[pl_idx] = pl_data;
    if (rst) begin
      check("wen_in_reset", 32'(mem_write_enable), 32'd0);
      m_cnt = 0;
    end else begin
      check("req_ready", 32'(req_ready), 32'(m_cnt == 0));
      check("resp_valid", 32'(resp_valid), 32'(m_cnt == 1));
      if (m_cnt > 0 && m_err)
        check("no_mem_on_err", 32'({mem_read_enable, mem_write_enable}), 32'd0);
      if (m_cnt == 1) begin
        check("resp_error", 32'(resp_error), 32'(m_err));
        check("resp_rdata", resp_rdata, m_rdata);
        if (m_wr) begin
          ref_mem[m_widx] = m_wword;
          check("mem_word", env_mem[m_widx], m_wword);
        end
      end
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (req_valid) model_accept(req_store, req_funct3, req_addr, req_wdata);
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // One directed request with literal expectations, starting from IDLE.
  task automatic do_req(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int          lat;
    logic [31:0] rd;
    logic        er;
    lat = 0;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        er  = resp_error;
      end
    end
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_rdata"}, rd, exp_rdata);
    check({nm, "_err"}, 32'(er), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        st;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    pl_en      = 1'b0;
    pl_idx     = 8'd0;
    pl_data    = 32'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    rst = 1'b0;

    // Reset state.
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", 32'(resp_error), 32'd0);
    check("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", mem_input_data, 32'd0);

    // Directed loads and stores.
    preload(8'h04, 32'h887766F5);
    do_req("lb_11",  1'b0, 3'd0, 32'h11, 32'd0, 32'h00000066, 1'b0, 2);
    do_req("lb_10",  1'b0, 3'd0, 32'h10, 32'd0, 32'hFFFFFFF5, 1'b0, 2);
    do_req("lbu_10", 1'b0, 3'd4, 32'h10, 32'd0, 32'h000000F5, 1'b0, 2);
    preload(8'h08, 32'h11223344);
    do_req("sb_22",  1'b1, 3'd0, 32'h22, 32'hAAAAAA3C, 32'd0, 1'b0, 3);
    do_req("lw_20",  1'b0, 3'd2, 32'h20, 32'd0, 32'h113C3344, 1'b0, 2);
    preload(8'h07, 32'h00000000);
    do_req("sh_1e",  1'b1, 3'd1, 32'h1E, 32'h0000BEEF, 32'd0, 1'b0, 3);
    check("sh_1e_mem", env_mem[7], 32'hBEEF0000);
    do_req("lh_1e",  1'b0, 3'd1, 32'h1E, 32'd0, 32'hFFFFBEEF, 1'b0, 2);
    do_req("lhu_1e", 1'b0, 3'd5, 32'h1E, 32'd0, 32'h0000BEEF, 1'b0, 2);
    do_req("sw_44",  1'b1, 3'd2, 32'h44, 32'h01020304, 32'd0, 1'b0, 2);
    check("sw_44_mem", env_mem[17], 32'h01020304);

    // Errors.
    do_req("err_lw06",  1'b0, 3'd2, 32'h06, 32'd0, 32'd0, 1'b1, 1);
    do_req("err_sh03",  1'b1, 3'd1, 32'h03, 32'd0, 32'd0, 1'b1, 1);
    do_req("err_f3_3",  1'b0, 3'd3, 32'h00, 32'd0, 32'd0, 1'b1, 1);
    do_req("err_lw400", 1'b0, 3'd2, 32'h400, 32'd0, 32'd0, 1'b1, 1);
    do_req("err_sb_f3", 1'b1, 3'd4, 32'h08, 32'd0, 32'd0, 1'b1, 1);

    // Reset during the WRITE cycle of an SW.
    preload(8'h10, 32'h0BADF00D);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h40;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    check("abort_mem", env_mem[16], 32'h0BADF00D);
    @(posedge clk);
    #1;

    // Randomized traffic; the first half keeps req_valid high throughout.
    for (int c = 0; c < 3000; c++) begin
      st = 1'($urandom % 2);
      if (st) f3 = ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom % 3);
      else    f3 = ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom % 6);
      a = 32'($urandom_range(0, 1023));
      if ($urandom % 4 != 0) begin
        if (f3[1:0] == 2'b10) a = a & ~32'd3;
        if (f3[1:0] == 2'b01) a = a & ~32'd1;
      end
      if ($urandom % 16 == 0) a = a | (32'h400 << ($urandom % 22));
      req_valid  = (c < 1500) ? 1'b1 : 1'($urandom % 4 != 0);
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = $urandom;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) check("final_mem", env_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
